// File: rtl/alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_sequencer
// Purpose  : Queues (op, A, B) requests and drives the serial-operand ALU
//            start/op/inbus protocol. Optional WAIT watchdog: ALU_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module alu_req_sequencer #(
  parameter int FIFO_DEPTH     = 2
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic        alu_ready,
  input  logic        alu_final,
  input  logic [15:0] alu_outbus,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_op,
  output logic        res_err
);

  localparam int         PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  entry_t           head;

  state_t           state_q, state_d;
  logic [1:0]       cur_op_q, cur_op_d;
  logic [7:0]       cur_b_q, cur_b_d;
  logic             alu_start_q, alu_start_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [7:0]       alu_inbus_q, alu_inbus_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_data_q, res_data_d;
  logic [1:0]       res_op_q, res_op_d;
  logic             res_err_q, res_err_d;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready comes from registered occupancy only, never from the pop decision.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{op: req_op, a: req_a, b: req_b};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cur_op_d    = cur_op_q;
    cur_b_d     = cur_b_q;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_inbus_d = alu_inbus_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && alu_ready) begin
          pop      = 1'b1;
          cur_op_d = head.op;
          cur_b_d  = head.b;
          if (head.op == OP_DIV && head.b == 8'h00) begin
            // Divide-by-zero is answered locally; the ALU never sees it.
            state_d     = S_OUT;
            res_valid_d = 1'b1;
            res_data_d  = 16'hFFFF;
            res_op_d    = head.op;
            res_err_d   = 1'b1;
          end else begin
            state_d     = S_LOAD_A;
            alu_start_d = 1'b1;
            alu_op_d    = head.op;
            alu_inbus_d = head.a;
          end
        end
      end
      S_LOAD_A: begin
        state_d     = S_LOAD_B;
        alu_inbus_d = cur_b_q;
      end
      S_LOAD_B: begin
        state_d     = S_WAIT;
        alu_inbus_d = 8'h00;
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_cnt_d   = 8'h00;
`endif
      end
      S_WAIT: begin
        if (alu_final) begin
          state_d     = S_OUT;
          res_valid_d = 1'b1;
          res_data_d  = alu_outbus;
          res_op_d    = cur_op_q;
          res_err_d   = 1'b0;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_OUT;
          res_valid_d = 1'b1;
          res_data_d  = 16'h0000;
          res_op_d    = cur_op_q;
          res_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      S_OUT: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cur_op_q    <= 2'b00;
      cur_b_q     <= 8'h00;
      alu_start_q <= 1'b0;
      alu_op_q    <= 2'b00;
      alu_inbus_q <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      res_op_q    <= 2'b00;
      res_err_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= 8'h00;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cur_op_q    <= cur_op_d;
      cur_b_q     <= cur_b_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      alu_inbus_q <= alu_inbus_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_inbus = alu_inbus_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_sequencer
// Purpose  : Self-checking bench for alu_req_sequencer with a behavioural ALU
//            responder and a queue-based result model.
// Revision : 1.0
// ============================================================================
module tb_alu_req_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a, req_b;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [7:0]  alu_inbus;
  logic        alu_ready, alu_final;
  logic [15:0] alu_outbus;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_op;
  logic        res_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;

  // ALU responder: captures A on the start cycle and B on the next one.
  int          alu_lat = 3;
  bit          m_hang  = 1'b0;
  logic        m_busy, m_final;
  int          m_cyc;
  logic [1:0]  m_op;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_out;
  logic        man_final;
  logic [15:0] man_out;

  assign alu_final  = m_final | man_final;
  assign alu_outbus = m_final ? m_out : man_out;

  alu_req_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_inbus(alu_inbus),
    .alu_ready(alu_ready), .alu_final(alu_final), .alu_outbus(alu_outbus),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_err(res_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      2'd0:    return {8'h00, a} + {8'h00, b};
      2'd1:    return {8'h00, a} - {8'h00, b};
      2'd2:    return {8'h00, a} * {8'h00, b};
      default: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
    endcase
  endfunction

  // Expected {data, err, op} for a request {op, a, b}.
  function automatic logic [18:0] ref_result(input logic [17:0] e);
    if (e[17:16] == 2'b11 && e[7:0] == 8'h00) return {16'hFFFF, 1'b1, e[17:16]};
    return {alu_fn(e[17:16], e[15:8], e[7:0]), 1'b0, e[17:16]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_final <= 1'b0;
      m_cyc   <= 0;
      m_out   <= 16'h0;
    end else begin
      m_final <= 1'b0;
      if (alu_start) begin
        m_busy <= 1'b1;
        m_cyc  <= 1;
        m_a    <= alu_inbus;
        m_op   <= alu_op;
      end else if (m_busy) begin
        if (m_cyc == 1) m_b <= alu_inbus;
        if (m_cyc + 1 == alu_lat && !m_hang) begin
          m_final <= 1'b1;
          m_out   <= alu_fn(m_op, m_a, m_b);
          m_busy  <= 1'b0;
        end
        m_cyc <= m_cyc + 1;
      end
    end
  end

  always @(posedge clk) if (alu_start === 1'b1) n_starts <= n_starts + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (alu_start !== 1'b0) $display("FAIL reset_alu_start: got %b want 0", alu_start); else n_pass++;
    n_checks++; if (alu_op !== 2'b00) $display("FAIL reset_alu_op: got %b want 00", alu_op); else n_pass++;
    n_checks++; if (alu_inbus !== 8'h00) $display("FAIL reset_alu_inbus: got %h want 00", alu_inbus); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== 16'h0) $display("FAIL reset_res_data: got %h want 0000", res_data); else n_pass++;
    n_checks++; if (res_op !== 2'b00) $display("FAIL reset_res_op: got %b want 00", res_op); else n_pass++;
    n_checks++; if (res_err !== 1'b0) $display("FAIL reset_res_err: got %b want 0", res_err); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int  s0, k;
    bit  seen;
    alu_lat = 3;
    s0 = n_starts;
    req_valid = 1'b1; req_op = 2'b00; req_a = 8'h12; req_b = 8'h34;
    tick();
    req_valid = 1'b0;
    n_checks++; if (alu_start !== 1'b0) $display("FAIL add_idle_start: got %b want 0", alu_start); else n_pass++;
    tick();
    n_checks++; if ({alu_start, alu_op, alu_inbus} !== {1'b1, 2'b00, 8'h12})
      $display("FAIL add_load_a: got start=%b op=%b bus=%h want 1/00/12", alu_start, alu_op, alu_inbus); else n_pass++;
    tick();
    n_checks++; if ({alu_start, alu_op, alu_inbus} !== {1'b0, 2'b00, 8'h34})
      $display("FAIL add_load_b: got start=%b op=%b bus=%h want 0/00/34", alu_start, alu_op, alu_inbus); else n_pass++;
    k = 1; seen = 1'b0;
    while (!seen && k < 20) begin
      tick(); k++;
      if (k == 2) begin
        n_checks++; if (alu_inbus !== 8'h00) $display("FAIL add_wait_bus: got %h want 00", alu_inbus); else n_pass++;
      end
      if (res_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (k !== 4) $display("FAIL add_latency: got %0d cycles want 4", k); else n_pass++;
    n_checks++; if ({res_data, res_err, res_op} !== {16'h0046, 1'b0, 2'b00})
      $display("FAIL add_result: got %h/%b/%b want 0046/0/00", res_data, res_err, res_op); else n_pass++;
    n_checks++; if (n_starts - s0 !== 1) $display("FAIL add_start_count: got %0d want 1", n_starts - s0); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL add_release: got %b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_div0();
    int s0;
    s0 = n_starts;
    req_valid = 1'b1; req_op = 2'b11; req_a = 8'h50; req_b = 8'h00;
    tick();
    req_valid = 1'b0;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL div0_early: got %b want 0", res_valid); else n_pass++;
    tick();
    n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, 16'hFFFF, 1'b1, 2'b11})
      $display("FAIL div0_result: got v=%b %h/%b/%b want 1 FFFF/1/11", res_valid, res_data, res_err, res_op); else n_pass++;
    repeat (3) tick();
    n_checks++; if (n_starts - s0 !== 0) $display("FAIL div0_no_start: got %0d starts want 0", n_starts - s0); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [17:0] q[$];
    logic [17:0] e;
    bit          rdy_seen;
    int          k;
    alu_lat = int'($urandom_range(3, 6));
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_op = 2'($urandom_range(0, 2)); req_a = 8'($urandom); req_b = 8'($urandom);
      n_checks++; if (req_ready !== 1'b1) $display("FAIL fill_accept_%0d: got %b want 1", i, req_ready); else n_pass++;
      q.push_back({req_op, req_a, req_b});
      tick();
    end
    req_op = 2'b01; req_a = 8'hAA; req_b = 8'h55;
    rdy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    n_checks++; if (rdy_seen !== 1'b0) $display("FAIL fill_full: got req_ready=1 want 0 while full"); else n_pass++;
    res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      k = 0;
      while (res_valid !== 1'b1 && k < 40) begin tick(); k++; end
      e = q.pop_front();
      n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, ref_result(e)})
        $display("FAIL fill_order_%0d: got v=%b %h/%b/%b want %h/%b/%b", j, res_valid, res_data, res_err,
                 res_op, ref_result(e)[18:3], ref_result(e)[2], ref_result(e)[1:0]); else n_pass++;
      tick();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [17:0] r1, r2;
    logic [15:0] d;
    bit          moved;
    int          k, s0;
    alu_lat = 4;
    r1 = {2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom)};
    r2 = {2'($urandom_range(0, 2)), 8'($urandom) | 8'h01, 8'($urandom)};
    req_valid = 1'b1; {req_op, req_a, req_b} = r1;
    tick();
    {req_op, req_a, req_b} = r2;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (res_valid !== 1'b1 && k < 40) begin tick(); k++; end
    n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, ref_result(r1)})
      $display("FAIL hold_first: got v=%b %h/%b/%b want %h", res_valid, res_data, res_err, res_op,
               ref_result(r1)); else n_pass++;
    d = res_data; s0 = n_starts; moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== d) moved = 1'b1;
    end
    n_checks++; if (moved !== 1'b0) $display("FAIL hold_stable: got changed output want stable %h", d); else n_pass++;
    n_checks++; if (n_starts - s0 !== 0) $display("FAIL hold_no_start: got %0d starts want 0", n_starts - s0); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if ({res_valid, alu_start} !== 2'b00)
      $display("FAIL hold_idle_gap: got valid=%b start=%b want 0/0", res_valid, alu_start); else n_pass++;
    tick();
    n_checks++; if ({alu_start, alu_inbus} !== {1'b1, r2[15:8]})
      $display("FAIL hold_restart: got start=%b bus=%h want 1/%h", alu_start, alu_inbus, r2[15:8]); else n_pass++;
    k = 0;
    while (res_valid !== 1'b1 && k < 40) begin tick(); k++; end
    n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, ref_result(r2)})
      $display("FAIL hold_second: got v=%b %h/%b/%b want %h", res_valid, res_data, res_err, res_op,
               ref_result(r2)); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit produced;
    int s0;
    m_hang = 1'b1;
    req_valid = 1'b1; req_op = 2'b10; req_a = 8'($urandom) | 8'h01; req_b = 8'h03;
    tick();
    req_op = 2'b00; req_a = 8'h11; req_b = 8'h22;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({req_ready, alu_start, alu_op, alu_inbus, res_valid, res_data, res_op, res_err} !==
                    {1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 16'h0000, 2'b00, 1'b0})
      $display("FAIL rstmid_outputs: got rdy=%b st=%b op=%b bus=%h v=%b d=%h rop=%b err=%b want reset values",
               req_ready, alu_start, alu_op, alu_inbus, res_valid, res_data, res_op, res_err); else n_pass++;
    tick();
    rst = 1'b0;
    m_hang = 1'b0;
    s0 = n_starts; produced = 1'b0;
    man_out = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      man_final = (i % 2 == 0);
      tick();
      if (res_valid !== 1'b0) produced = 1'b1;
    end
    man_final = 1'b0;
    n_checks++; if (produced !== 1'b0) $display("FAIL rstmid_no_result: got res_valid=1 want 0"); else n_pass++;
    n_checks++; if (n_starts - s0 !== 0) $display("FAIL rstmid_no_start: got %0d starts want 0", n_starts - s0); else n_pass++;
  endtask

  task automatic test_wait();
    int k;
    logic [17:0] r;
    m_hang = 1'b1;
    r = {2'b01, 8'h77, 8'h05};
    req_valid = 1'b1; {req_op, req_a, req_b} = r;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (alu_start !== 1'b1) $display("FAIL wait_start: got %b want 1", alu_start); else n_pass++;
`ifdef ALU_SEQ_TIMEOUT_EN
    k = 0;
    while (res_valid !== 1'b1 && k < 400) begin tick(); k++; end
    n_checks++; if (k !== 257) $display("FAIL tmo_latency: got %0d cycles want 257", k); else n_pass++;
    n_checks++; if ({res_data, res_err, res_op} !== {16'h0000, 1'b1, 2'b01})
      $display("FAIL tmo_result: got %h/%b/%b want 0000/1/01", res_data, res_err, res_op); else n_pass++;
    man_out = 16'h1234; man_final = 1'b1;
    tick();
    man_final = 1'b0;
    n_checks++; if ({res_valid, res_data} !== {1'b1, 16'h0000})
      $display("FAIL tmo_late_final: got v=%b d=%h want 1/0000", res_valid, res_data); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    m_hang = 1'b0;
    r = {2'b10, 8'h0F, 8'h11};
    req_valid = 1'b1; {req_op, req_a, req_b} = r;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (res_valid !== 1'b1 && k < 40) begin tick(); k++; end
    n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, ref_result(r)})
      $display("FAIL tmo_recover: got v=%b %h/%b/%b want %h", res_valid, res_data, res_err, res_op,
               ref_result(r)); else n_pass++;
`else
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (res_valid !== 1'b0) k++;
    end
    n_checks++; if (k !== 0) $display("FAIL wait_hold: got res_valid in %0d cycles want 0", k); else n_pass++;
    man_out = 16'($urandom); man_final = 1'b1;
    tick();
    man_final = 1'b0;
    n_checks++; if ({res_valid, res_data, res_err, res_op} !== {1'b1, man_out, 1'b0, 2'b01})
      $display("FAIL wait_release: got v=%b %h/%b/%b want 1 %h/0/01", res_valid, res_data, res_err,
               res_op, man_out); else n_pass++;
`endif
    m_hang = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e;
    logic [18:0] got_v;
    bit          acc_req, acc_res;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    alu_lat = int'($urandom_range(3, 7));
    while (got < 40 && cyc < 4000) begin
      if (req_valid !== 1'b1 && sent < 40 && $urandom_range(0, 2) != 0) begin
        req_valid = 1'b1;
        req_op = 2'($urandom_range(0, 3));
        req_a = 8'($urandom);
        req_b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      res_ready = 1'($urandom_range(0, 1));
      alu_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_req = req_valid && req_ready;
      acc_res = res_valid && res_ready;
      got_v   = {res_data, res_err, res_op};
      @(posedge clk);
      #1;
      cyc++;
      if (acc_req) begin
        q.push_back({req_op, req_a, req_b});
        sent++;
        req_valid = 1'b0;
      end
      if (acc_res) begin
        e = (q.size() > 0) ? q.pop_front() : 18'h0;
        n_checks++; if (got_v !== ref_result(e))
          $display("FAIL rand_result_%0d: got %h/%b/%b want %h/%b/%b (op=%b a=%h b=%h)", got, got_v[18:3],
                   got_v[2], got_v[1:0], ref_result(e)[18:3], ref_result(e)[2], ref_result(e)[1:0],
                   e[17:16], e[15:8], e[7:0]); else n_pass++;
        got++;
      end
    end
    n_checks++; if (got !== 40) $display("FAIL rand_count: got %0d results want 40", got); else n_pass++;
    req_valid = 1'b0; res_ready = 1'b0; alu_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00;
    alu_ready = 1'b1; res_ready = 1'b0;
    man_final = 1'b0; man_out = 16'h0000;
    test_reset();
    test_add();
    test_div0();
    test_fill();
    test_hold();
    test_reset_mid();
    test_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 time units want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_req_sequencer.md
# alu_req_sequencer

Front-end sequencer that sits directly upstream of the 8-bit serial-operand ALU. It accepts whole operation requests (op, A, B) over a valid/ready handshake and buffers them in a 2-entry FIFO. It drives the ALU's start/op/inbus port protocol one operand per cycle, waits for the ALU's completion pulse, captures the 16-bit result and returns it on a valid/ready result port. It also screens divide-by-zero requests and, optionally, recovers from a hung ALU.

## Interface
- `FIFO_DEPTH`, 2: request FIFO entries. Fixed; other values are unsupported.
- `TIMEOUT_CYCLES`, 255: WAIT-state watchdog limit. Used only with `ALU_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_op` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `req_a` in 8: operand A.
- `req_b` in 8: operand B.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_op` out 2: op to the ALU, held stable from LOAD_A through WAIT.
- `alu_inbus` out 8: ALU data bus.
- `alu_ready` in 1: ALU idle and able to take a start.
- `alu_final` in 1: ALU result valid on `alu_outbus` this cycle.
- `alu_outbus` in 16: ALU result.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 16: result value.
- `res_op` out 2: op of the returned result.
- `res_err` out 1: div-by-zero or timeout.

## Operation
- Request FIFO
  - Push on `req_valid && req_ready`.
  - `req_ready = !full`, derived from registered occupancy only.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
  - Entry order is strictly preserved.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, OUT.
- IDLE
  - Pop happens when the FIFO is non-empty and `alu_ready` = 1.
  - Popped entry with op=11 and B=0: go to OUT with `res_data` = 16'hFFFF and `res_err` = 1. The ALU is untouched.
  - Any other popped entry: go to LOAD_A.
- LOAD_A
  - Outputs: `alu_start` = 1, `alu_inbus` = A, `alu_op` = op.
  - Next state: LOAD_B.
- LOAD_B
  - Outputs: `alu_start` = 0, `alu_inbus` = B.
  - Next state: WAIT.
- WAIT
  - Output: `alu_inbus` = 0.
  - When `alu_final` = 1, capture `alu_outbus` into `res_data` with `res_err` = 0 and go to OUT.
- OUT
  - `res_valid` = 1; `res_data`, `res_op` and `res_err` are stable.
  - On `res_ready` = 1, go to IDLE.
- `alu_final` is ignored in every state except WAIT.
- All ALU-side and result-side outputs are registered. None depends combinationally on any input.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `alu_start` = 0, `alu_op` = 00, `alu_inbus` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_op` = 00, `res_err` = 0.
  - FIFO empty, state IDLE.
- Accept-to-start latency: a request accepted at edge e0 into an empty FIFO, with `alu_ready` = 1, puts `alu_start` high in the cycle after edge e1. A is on the bus that cycle; B is on the bus in the following cycle.
- Result latency: `res_valid` rises the cycle after `alu_final` is sampled high in WAIT.
- Div-by-zero path: `res_valid` rises the cycle after the pop.
- Back-to-back: the next pop can occur on the edge that leaves OUT, i.e. the cycle after `res_ready` is sampled. This gives one IDLE cycle minimum between operations.
- Full FIFO: `req_ready` is low; a request presented then is not accepted and must be held by the source.
- Reset mid-operation: all state is dropped immediately and asynchronously. Queued and in-flight requests are lost, and `alu_start` falls without completing the pulse.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If `TIMEOUT_CYCLES` WAIT cycles elapse without `alu_final`, go to OUT with `res_data` = 0 and `res_err` = 1.
  - A late `alu_final` after the timeout is ignored.
- `ALU_SEQ_TIMEOUT_EN` undefined:
  - No counter is present; WAIT holds indefinitely.
  - `res_err` is set only by div-by-zero.

## Test plan
- Add request (op=00, A=8'h12, B=8'h34); ALU model asserts `alu_final` 3 cycles after `alu_start` with 16'h0046.
  - Required: `alu_start` pulse of exactly one cycle, `alu_inbus` 12 then 34, `res_data` = 16'h0046, `res_err` = 0, `res_op` = 00.
- Div request (op=11, A=8'h50, B=0).
  - Required: no `alu_start`; `res_valid` the cycle after the pop with `res_data` = 16'hFFFF and `res_err` = 1.
- Three requests pushed on consecutive cycles while `res_ready` = 0.
  - Required: `req_ready` drops after two are queued plus the one in flight.
  - Required: results return in push order once `res_ready` = 1.
- `res_ready` held low for 10 cycles in OUT.
  - Required: `res_data` is stable and no new `alu_start` is issued.
  - Required: the next `alu_start` comes 2 cycles after `res_ready` is sampled high.
- `rst` asserted during WAIT with one entry queued.
  - Required: all outputs return to reset values asynchronously.
  - Required: after release, `alu_final` pulses are ignored and no result is produced.
- With `ALU_SEQ_TIMEOUT_EN` defined, the ALU model never asserts `alu_final`.
  - Required: `res_valid` with `res_data` = 0 and `res_err` = 1 after 255 WAIT cycles.
  - Required: a subsequent request completes normally.
